// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-file geometry and architectural register indices.
package mips_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int DEF_DATA_W = 32;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = 5'd0;
   localparam reg_idx_t REG_SP   = 5'd29;
   localparam reg_idx_t REG_RA   = 5'd31;

   function automatic logic is_zero_reg(input reg_idx_t idx);
      return idx == REG_ZERO;
   endfunction

endpackage

// File: rtl/register_file_if.sv
// Register-file bus: two read ports, one write port and a debug peek port.
interface register_file_if #(parameter int DATA_W = mips_pkg::DEF_DATA_W) ();
   import mips_pkg::*;

   reg_idx_t          read_reg1;
   reg_idx_t          read_reg2;
   reg_idx_t          write_reg;
   logic [DATA_W-1:0] write_data;
   logic              reg_write;
   logic [DATA_W-1:0] read_data1;
   logic [DATA_W-1:0] read_data2;
   reg_idx_t          dbg_reg;
   logic [DATA_W-1:0] dbg_data;

   modport master (
      output read_reg1, read_reg2, write_reg, write_data, reg_write, dbg_reg,
      input  read_data1, read_data2, dbg_data
   );

   modport slave (
      input  read_reg1, read_reg2, write_reg, write_data, reg_write, dbg_reg,
      output read_data1, read_data2, dbg_data
   );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: index decode, hard-wired r0 and optional write-through forwarding.
module regfile_read_port
   import mips_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter bit BYPASS = 1'b1
) (
   input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
   input  reg_idx_t                        read_idx_i,
   input  logic                            wr_en_i,
   input  reg_idx_t                        wr_idx_i,
   input  logic [DATA_W-1:0]               wr_data_i,
   output logic [DATA_W-1:0]               read_data_o
);

   // r0 wins over forwarding so a discarded write to index 0 never leaks out.
   always_comb begin
      read_data_o = regs_i[read_idx_i];
      if (is_zero_reg(read_idx_i)) begin
         read_data_o = '0;
      end else if (BYPASS && wr_en_i && (wr_idx_i == read_idx_i)) begin
         read_data_o = wr_data_i;
      end
   end

endmodule

// File: rtl/register_file.sv
// 32-entry MIPS register file with two combinational read ports, one write port and a debug port.
module register_file
   import mips_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter bit BYPASS = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   register_file_if.slave  bus
);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
   logic                            wrEn;

   // Gating with rst_n keeps forwarding off while the array is held clear.
   assign wrEn = bus.reg_write && rst_n && !is_zero_reg(bus.write_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '0;
      end else if (wrEn) begin
         regs_q[bus.write_reg] <= bus.write_data;
      end
   end

   regfile_read_port #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_port1 (
      .regs_i      (regs_q),
      .read_idx_i  (bus.read_reg1),
      .wr_en_i     (wrEn),
      .wr_idx_i    (bus.write_reg),
      .wr_data_i   (bus.write_data),
      .read_data_o (bus.read_data1)
   );

   regfile_read_port #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_port2 (
      .regs_i      (regs_q),
      .read_idx_i  (bus.read_reg2),
      .wr_en_i     (wrEn),
      .wr_idx_i    (bus.write_reg),
      .wr_data_i   (bus.write_data),
      .read_data_o (bus.read_data2)
   );

   assign bus.dbg_data = is_zero_reg(bus.dbg_reg) ? '0 : regs_q[bus.dbg_reg];

endmodule
